uart_core_param: RTL and testbench

Parametrised full-duplex UART core, the successor to the fixed 8N1 TX/RX pair, which relied on an external shared baud clock. It has an internal baud generator, configurable data width, run-time parity and stop-bit modes, and 16x-oversampled RX with glitch rejection and majority voting. It offers valid/ready handshakes on both byte interfaces and reports parity, framing and overrun errors. It sits between the system bus logic and the serial pins.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_gen.sv | 33 +++
 rtl/uart_core_param.sv | 203 ++++++++++++++++++++
 tb/tb_uart_core_param.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared constants, FSM state codes and parity helper for the UART
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 8;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t TX_IDLE   = 3'd0;
    localparam uart_state_t TX_START  = 3'd1;
    localparam uart_state_t TX_DATA   = 3'd2;
    localparam uart_state_t TX_PARITY = 3'd3;
    localparam uart_state_t TX_STOP   = 3'd4;

    localparam uart_state_t RX_IDLE   = 3'd0;
    localparam uart_state_t RX_START  = 3'd1;
    localparam uart_state_t RX_DATA   = 3'd2;
    localparam uart_state_t RX_PARITY = 3'd3;
    localparam uart_state_t RX_STOP   = 3'd4;

    // Payload is zero-extended to the widest legal frame (9 bits).
    function automatic logic parity_bit(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// uart_baud_gen : modulo-DIV counter emitting a one-clk tick on its last count
// Revision : 1.0
// ============================================================================
module uart_baud_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == LAST) && !clr;

endmodule
`default_nettype wire

// File: rtl/uart_core_param.sv
`default_nettype none
// ============================================================================
// uart_core_param : full-duplex UART, internal baud generation, 16x RX voting
// Revision : 1.0
// ============================================================================
module uart_core_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS     = 8,
    parameter int CLKS_PER_TICK = 27
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_parity_en,
    input  logic                 cfg_parity_odd,
    input  logic                 cfg_two_stop,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_out,
    input  logic                 rx_serial,
    input  logic                 rx_ready,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    localparam int IDX_W = $clog2(DATA_BITS + 1);

    // ---------------- transmitter ----------------
    uart_state_t          tx_state;
    logic [DATA_BITS-1:0] tx_shift;
    logic [IDX_W-1:0]     tx_idx;
    logic                 tx_par, tx_par_en, tx_two_stop, tx_second;
    logic                 tx_tick, tx_accept;

    assign tx_ready  = (tx_state == TX_IDLE);
    assign tx_accept = tx_valid && tx_ready;

    uart_baud_gen #(.DIV(OVERSAMPLE * CLKS_PER_TICK)) u_tx_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (tx_accept),
        .tick (tx_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state    <= TX_IDLE;
            tx_shift    <= '0;
            tx_idx      <= '0;
            tx_par      <= 1'b0;
            tx_par_en   <= 1'b0;
            tx_two_stop <= 1'b0;
            tx_second   <= 1'b0;
            tx_out      <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: if (tx_accept) begin
                    tx_state    <= TX_START;
                    tx_shift    <= tx_data;
                    tx_par      <= parity_bit(9'(tx_data), cfg_parity_odd);
                    tx_par_en   <= cfg_parity_en;
                    tx_two_stop <= cfg_two_stop;
                    tx_second   <= 1'b0;
                    tx_idx      <= '0;
                    tx_out      <= 1'b0;
                end
                TX_START: if (tx_tick) begin
                    tx_state <= TX_DATA;
                    tx_out   <= tx_shift[0];
                    tx_shift <= tx_shift >> 1;
                    tx_idx   <= IDX_W'(1);
                end
                TX_DATA: if (tx_tick) begin
                    // tx_idx counts data bits already placed on the line
                    if (tx_idx == IDX_W'(DATA_BITS)) begin
                        tx_state <= tx_par_en ? TX_PARITY : TX_STOP;
                        tx_out   <= tx_par_en ? tx_par : 1'b1;
                    end else begin
                        tx_out   <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_idx   <= tx_idx + IDX_W'(1);
                    end
                end
                TX_PARITY: if (tx_tick) begin
                    tx_state <= TX_STOP;
                    tx_out   <= 1'b1;
                end
                TX_STOP: if (tx_tick) begin
                    if (tx_two_stop && !tx_second) tx_second <= 1'b1;
                    else                           tx_state  <= TX_IDLE;
                end
                default: begin
                    tx_state <= TX_IDLE;
                    tx_out   <= 1'b1;
                end
            endcase
        end
    end

    // ---------------- receiver ----------------
    uart_state_t          rx_state;
    logic                 sync1, sync2;
    logic [3:0]           rx_tick_cnt, tick_next;
    logic [IDX_W-1:0]     rx_idx;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 vote0, vote1, vote, decide, load;
    logic                 rx_par_en, rx_par_odd, rx_perr;
    logic                 rx_tick;

    uart_baud_gen #(.DIV(CLKS_PER_TICK)) u_rx_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (rx_state == RX_IDLE),
        .tick (rx_tick)
    );

    // Three samples straddle MID_TICK; the decision is taken on the last one.
    assign tick_next = rx_tick_cnt + 4'd1;
    assign vote      = (vote0 & vote1) | (vote0 & sync2) | (vote1 & sync2);
    assign decide    = rx_tick && (tick_next == 4'(MID_TICK + 1));
    assign load      = decide && (rx_state == RX_STOP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx_serial;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state      <= RX_IDLE;
            rx_tick_cnt   <= '0;
            rx_idx        <= '0;
            rx_shift      <= '0;
            vote0         <= 1'b1;
            vote1         <= 1'b1;
            rx_par_en     <= 1'b0;
            rx_par_odd    <= 1'b0;
            rx_perr       <= 1'b0;
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            if (rx_tick) rx_tick_cnt <= tick_next;
            if (rx_tick && tick_next == 4'(MID_TICK - 1)) vote0 <= sync2;
            if (rx_tick && tick_next == 4'(MID_TICK))     vote1 <= sync2;

            case (rx_state)
                RX_IDLE: begin
                    rx_tick_cnt <= '0;
                    if (!sync2) rx_state <= RX_START;
                end
                RX_START: if (decide) begin
                    if (vote) begin
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_state   <= RX_DATA;
                        rx_idx     <= '0;
                        rx_par_en  <= cfg_parity_en;
                        rx_par_odd <= cfg_parity_odd;
                        rx_perr    <= 1'b0;
                    end
                end
                RX_DATA: if (decide) begin
                    rx_shift <= {vote, rx_shift[DATA_BITS-1:1]};
                    if (rx_idx == IDX_W'(DATA_BITS - 1))
                        rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
                    else
                        rx_idx <= rx_idx + IDX_W'(1);
                end
                RX_PARITY: if (decide) begin
                    rx_perr  <= (vote != parity_bit(9'(rx_shift), rx_par_odd));
                    rx_state <= RX_STOP;
                end
                RX_STOP: if (decide) rx_state <= RX_IDLE;
                default: rx_state <= RX_IDLE;
            endcase

            if (load) begin
                rx_data       <= rx_shift;
                rx_parity_err <= rx_perr;
                rx_frame_err  <= !vote;
                rx_valid      <= 1'b1;
                rx_overrun    <= rx_valid && !rx_ready;
            end else if (rx_valid && rx_ready) begin
                rx_valid   <= 1'b0;
                rx_overrun <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_core_param.sv
`default_nettype none
// ============================================================================
// tb_uart_core_param : randomized bench with a cycle-level TX line model and
//                      frame-level RX expectations. Revision : 1.0
// ============================================================================
module tb_uart_core_param;

    localparam int DB  = 8;
    localparam int CPT = 4;
    localparam int BIT = 16 * CPT;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_parity_en = 1'b0, cfg_parity_odd = 1'b0, cfg_two_stop = 1'b0;
    logic          tx_valid = 1'b0;
    logic [DB-1:0] tx_data = '0;
    logic          tx_ready, tx_out;
    logic          rx_ready = 1'b0;
    logic          rx_valid;
    logic [DB-1:0] rx_data;
    logic          rx_parity_err, rx_frame_err, rx_overrun;
    logic          loop_en = 1'b0, drv_line = 1'b1;
    logic          rx_line;

    assign rx_line = loop_en ? tx_out : drv_line;

    always #5 clk = ~clk;

    uart_core_param #(.DATA_BITS(DB), .CLKS_PER_TICK(CPT)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_two_stop   (cfg_two_stop),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .tx_out         (tx_out),
        .rx_serial      (rx_line),
        .rx_ready       (rx_ready),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_parity_err  (rx_parity_err),
        .rx_frame_err   (rx_frame_err),
        .rx_overrun     (rx_overrun)
    );

    int errors = 0;
    int checks = 0;
    int nprint = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Line image of one frame, index = bit position on the wire; unused tail is idle 1.
    function automatic logic [11:0] frame_vec(input logic [7:0] d, input logic pe, input logic po);
        logic [11:0] v;
        v    = '1;
        v[0] = 1'b0;
        for (int i = 0; i < 8; i++) v[i+1] = d[i];
        if (pe) v[9] = (^d) ^ po;
        return v;
    endfunction

    logic        m_busy;
    int          m_cnt, m_total;
    logic [11:0] m_vec;
    logic        exp_line;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy  <= 1'b0;
            m_cnt   <= 0;
            m_total <= 0;
            m_vec   <= '1;
        end else if (m_busy) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == m_total) m_busy <= 1'b0;
        end else if (tx_valid) begin
            m_busy  <= 1'b1;
            m_cnt   <= 0;
            m_vec   <= frame_vec(tx_data, cfg_parity_en, cfg_parity_odd);
            m_total <= BIT * (10 + int'(cfg_parity_en) + int'(cfg_two_stop));
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_line = m_busy ? m_vec[m_cnt / BIT] : 1'b1;
            checks++;
            if (tx_out !== exp_line || tx_ready !== !m_busy) begin
                errors++;
                if (nprint < 10)
                    $display("FAIL tx_cycle t=%0t: tx_out=%b want %b, tx_ready=%b want %b",
                             $time, tx_out, exp_line, tx_ready, !m_busy);
                nprint++;
            end
        end
    end

    task automatic tx_frame(input logic [7:0] d, input logic pe, input logic po, input logic ts,
                            output int low_cnt, output logic [11:0] cap);
        int k;
        k = 0;
        while (!tx_ready && k < 3000) begin
            @(negedge clk);
            k++;
        end
        cfg_parity_en  = pe;
        cfg_parity_odd = po;
        cfg_two_stop   = ts;
        tx_data        = d;
        tx_valid       = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = DB'($urandom);
        cap      = '1;
        k        = 0;
        while (!tx_ready && k < 2000) begin
            if (k >= 32 && (k - 32) % BIT == 0 && (k - 32) / BIT < 12)
                cap[(k - 32) / BIT] = tx_out;
            // Scramble config mid-frame; the frame in flight must ignore it.
            if (k == 200) begin
                cfg_parity_en  = 1'($urandom);
                cfg_parity_odd = 1'($urandom);
                cfg_two_stop   = 1'($urandom);
            end
            k++;
            @(negedge clk);
        end
        low_cnt = k;
    endtask

    task automatic rx_drive(input logic [7:0] d, input logic pe, input logic pbit,
                            input logic stopbit, input int gbit);
        logic [10:0] v;
        int n;
        v    = '1;
        v[0] = 1'b0;
        for (int i = 0; i < 8; i++) v[i+1] = d[i];
        n = 9;
        if (pe) begin
            v[9] = pbit;
            n    = 10;
        end
        v[n] = stopbit;
        n++;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < BIT; c++) begin
                if (i == n - 1 && !stopbit) drv_line = (c < 44) ? 1'b0 : 1'b1;
                else                        drv_line = v[i] ^ (i == gbit && c == 33);
                @(negedge clk);
            end
        end
        drv_line = 1'b1;
    endtask

    task automatic rx_expect(input string name, input logic [7:0] d, input logic pe,
                             input logic fe, input logic ov);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (rx_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_valid: rx_valid never rose, expected 1", name);
        end
        check({name, "_data"}, rx_data, d);
        check({name, "_perr"}, rx_parity_err, pe);
        check({name, "_ferr"}, rx_frame_err, fe);
        check({name, "_ovr"}, rx_overrun, ov);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check({name, "_consumed"}, rx_valid, 1'b0);
        check({name, "_ovr_clr"}, rx_overrun, 1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int          low;
        logic [11:0] cap;
        logic [7:0]  d;
        logic        pe, po, ts, pinj, sbad;

        repeat (3) @(negedge clk);
        check("rst_tx_out", tx_out, 1'b1);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_flags", {rx_parity_err, rx_frame_err, rx_overrun}, 3'b000);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Plain TX frame with hand-derived line image.
        tx_frame(8'hA5, 1'b0, 1'b0, 1'b0, low, cap);
        check("t1_bits", cap, 12'hF4A);
        check("t1_busy_clks", low, 640);
        repeat (20) @(negedge clk);

        // Loopback with parity and stop variants.
        loop_en = 1'b1;
        tx_frame(8'h3C, 1'b1, 1'b0, 1'b0, low, cap);
        check("t2_even_bits", cap, 12'hC78);
        rx_expect("t2_even", 8'h3C, 1'b0, 1'b0, 1'b0);
        tx_frame(8'h3C, 1'b1, 1'b1, 1'b0, low, cap);
        check("t2_odd_bits", cap, 12'hE78);
        rx_expect("t2_odd", 8'h3C, 1'b0, 1'b0, 1'b0);
        tx_frame(8'h3C, 1'b1, 1'b0, 1'b1, low, cap);
        check("t2_two_stop_clks", low, 768);
        rx_expect("t2_two_stop", 8'h3C, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            d  = 8'($urandom);
            pe = 1'($urandom);
            po = 1'($urandom);
            ts = 1'($urandom);
            tx_frame(d, pe, po, ts, low, cap);
            check("rnd_loop_clks", low, BIT * (10 + int'(pe) + int'(ts)));
            rx_expect("rnd_loop", d, 1'b0, 1'b0, 1'b0);
        end
        repeat (20) @(negedge clk);
        loop_en = 1'b0;

        // Directly driven RX frames with injected errors.
        cfg_parity_en  = 1'b1;
        cfg_parity_odd = 1'b0;
        rx_drive(8'h3C, 1'b1, 1'b1, 1'b1, -1);
        repeat (100) @(negedge clk);
        rx_expect("t3_perr", 8'h3C, 1'b1, 1'b0, 1'b0);
        cfg_parity_en = 1'b0;
        rx_drive(8'h96, 1'b0, 1'b0, 1'b0, -1);
        repeat (100) @(negedge clk);
        rx_expect("t3_ferr", 8'h96, 1'b0, 1'b1, 1'b0);

        // Short low pulse is rejected, clean frame afterwards, then a data-bit glitch.
        drv_line = 1'b0;
        repeat (16) @(negedge clk);
        drv_line = 1'b1;
        repeat (200) @(negedge clk);
        check("t4_glitch_no_valid", rx_valid, 1'b0);
        rx_drive(8'h55, 1'b0, 1'b0, 1'b1, -1);
        repeat (100) @(negedge clk);
        rx_expect("t4_after_glitch", 8'h55, 1'b0, 1'b0, 1'b0);
        rx_drive(8'hA3, 1'b0, 1'b0, 1'b1, 3);
        repeat (100) @(negedge clk);
        rx_expect("t4_bit_glitch", 8'hA3, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            d    = 8'($urandom);
            pe   = 1'($urandom);
            po   = 1'($urandom);
            pinj = 1'($urandom);
            sbad = 1'($urandom);
            cfg_parity_en  = pe;
            cfg_parity_odd = po;
            rx_drive(d, pe, (^d) ^ po ^ pinj, !sbad, $urandom_range(1, 8));
            repeat (100) @(negedge clk);
            rx_expect("rnd_rx", d, pe && pinj, sbad, 1'b0);
        end

        // Overrun: second frame overwrites an unconsumed first frame.
        cfg_parity_en = 1'b0;
        rx_drive(8'h11, 1'b0, 1'b0, 1'b1, -1);
        rx_drive(8'h22, 1'b0, 1'b0, 1'b1, -1);
        repeat (100) @(negedge clk);
        rx_expect("t5_overrun", 8'h22, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a loopback frame.
        loop_en        = 1'b1;
        cfg_parity_en  = 1'b0;
        cfg_two_stop   = 1'b0;
        tx_data        = 8'h5A;
        tx_valid       = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (200) @(negedge clk);
        #3 rst = 1'b0;
        #1;
        check("t6_async_tx_out", tx_out, 1'b1);
        check("t6_async_tx_ready", tx_ready, 1'b1);
        check("t6_async_rx_valid", rx_valid, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (1000) @(negedge clk);
        check("t6_no_partial_rx", rx_valid, 1'b0);
        tx_frame(8'h81, 1'b0, 1'b0, 1'b0, low, cap);
        check("t6_bits", cap, frame_vec(8'h81, 1'b0, 1'b0));
        check("t6_clks", low, 640);
        rx_expect("t6_rx", 8'h81, 1'b0, 1'b0, 1'b0);

        repeat (20) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
